// File: rtl/storage_bist_pkg.sv
// Shared types and checkpoint-code helpers for the storage SRAM self-test engine.
package storage_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WRITE,
    S_READ,
    S_CHECK,
    S_PASS,
    S_FAIL,
    S_DONE
  } state_t;

  localparam logic [7:0] CODE_HDR_START  = 8'hA0;
  localparam logic [7:0] CODE_HDR_RESULT = 8'hAB;
  localparam logic [7:0] CODE_TAG_BASE   = 8'h40;

  // Block k is tagged by a single walking bit; the pass flag rides in bit 0.
  function automatic logic [15:0] make_code(input logic [7:0] hdr,
                                            input logic [2:0] blk,
                                            input logic       pass);
    logic [7:0] tag;
    tag = CODE_TAG_BASE >> blk;
    return {hdr, tag | {7'b0, pass}};
  endfunction

endpackage

// File: rtl/storage_bist_if.sv
// Shared SRAM bus between the BIST engine and the storage macros.
interface storage_bist_if #(
  parameter int unsigned NBLOCKS = 2,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32
);
  logic [NBLOCKS-1:0]        mem_csb;
  logic                      mem_web;
  logic [DATA_W/8-1:0]       mem_wmask;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_din;
  logic [NBLOCKS*DATA_W-1:0] mem_dout;

  modport master (
    output mem_csb, mem_web, mem_wmask, mem_addr, mem_din,
    input  mem_dout
  );

  modport slave (
    input  mem_csb, mem_web, mem_wmask, mem_addr, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/storage_bist_cmp.sv
// Pattern generator and readback comparator; tracks the address whose data
// arrives one cycle after the read was issued.
module storage_bist_cmp
  import storage_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter logic [31:0] SEED   = 32'hA5A5_0F0F
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] pat_addr,
  output logic [DATA_W-1:0] pat_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              mismatch,
  output logic [ADDR_W-1:0] mis_addr
);

  logic              rd_valid_q;
  logic [ADDR_W-1:0] rd_addr_q;

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    return DATA_W'(SEED) + DATA_W'(a);
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
    end else begin
      rd_valid_q <= rd_en;
      rd_addr_q  <= rd_addr;
    end
  end

  assign pat_data = pattern(pat_addr);
  assign mismatch = rd_valid_q && (rd_data != pattern(rd_addr_q));
  assign mis_addr = rd_addr_q;

endmodule

// File: rtl/storage_bist.sv
// Storage SRAM BIST: write/readback of each block in turn with checkpoint codes.
module storage_bist
  import storage_bist_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NBLOCKS    = 2,
  parameter int unsigned TEST_WORDS = 2**ADDR_W,
  parameter logic [31:0] SEED       = 32'hA5A5_0F0F
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  storage_bist_if.master    mem,
  output logic [15:0]       status,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [2:0]        err_blk,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [ADDR_W:0] TW_L     = (ADDR_W+1)'(TEST_WORDS);
  localparam logic [2:0]      LAST_BLK = 3'(NBLOCKS-1);

  state_t              state_q, state_n;
  logic [2:0]          k_q, k_n;
  logic [ADDR_W:0]     addr_q, addr_n, addr_inc;
  logic [15:0]         status_n;
  logic                done_n, fail_n, busy_n;
  logic [2:0]          err_blk_n;
  logic [ADDR_W-1:0]   err_addr_n;

  logic [NBLOCKS-1:0]  csb_q, csb_n;
  logic                web_q, web_n;
  logic [DATA_W/8-1:0] wmask_q, wmask_n;
  logic [ADDR_W-1:0]   maddr_q, maddr_n;
  logic [DATA_W-1:0]   din_q, din_n;

  logic [DATA_W-1:0]   pat_data, rd_word;
  logic                mismatch;
  logic [ADDR_W-1:0]   mis_addr;

  always_comb begin
    rd_word = '0;
    for (int unsigned b = 0; b < NBLOCKS; b++)
      if (k_q == 3'(b)) rd_word = mem.mem_dout[b*DATA_W +: DATA_W];
  end

  storage_bist_cmp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .SEED   (SEED)
  ) u_cmp (
    .clk      (clk),
    .resetn   (resetn),
    .pat_addr (addr_n[ADDR_W-1:0]),
    .pat_data (pat_data),
    .rd_en    (state_q == S_READ),
    .rd_addr  (addr_q[ADDR_W-1:0]),
    .rd_data  (rd_word),
    .mismatch (mismatch),
    .mis_addr (mis_addr)
  );

  always_comb begin
    state_n    = state_q;
    k_n        = k_q;
    addr_n     = addr_q;
    status_n   = status;
    done_n     = done;
    fail_n     = fail;
    err_blk_n  = err_blk;
    err_addr_n = err_addr;
    addr_inc   = addr_q + (ADDR_W+1)'(1);
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          state_n    = S_START;
          k_n        = '0;
          addr_n     = '0;
          done_n     = 1'b0;
          fail_n     = 1'b0;
          err_blk_n  = '0;
          err_addr_n = '0;
          status_n   = make_code(CODE_HDR_START, 3'd0, 1'b0);
        end
      end
      S_START: begin
        state_n = S_WRITE;
        addr_n  = '0;
      end
      S_WRITE: begin
        if (addr_inc == TW_L) begin
          state_n = S_READ;
          addr_n  = '0;
        end else begin
          addr_n = addr_inc;
        end
      end
      // READ and CHECK share the compare of the word read one cycle earlier.
      S_READ, S_CHECK: begin
        if (mismatch) begin
          state_n    = S_FAIL;
          addr_n     = '0;
          status_n   = make_code(CODE_HDR_RESULT, k_q, 1'b0);
          done_n     = 1'b1;
          fail_n     = 1'b1;
          err_blk_n  = k_q;
          err_addr_n = mis_addr;
        end else if (state_q == S_CHECK) begin
          state_n  = S_PASS;
          status_n = make_code(CODE_HDR_RESULT, k_q, 1'b1);
        end else if (addr_inc == TW_L) begin
          state_n = S_CHECK;
          addr_n  = '0;
        end else begin
          addr_n = addr_inc;
        end
      end
      S_PASS: begin
        if (k_q == LAST_BLK) begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end else begin
          k_n      = k_q + 3'd1;
          state_n  = S_START;
          status_n = make_code(CODE_HDR_START, k_n, 1'b0);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so they line up with it.
  always_comb begin
    busy_n  = (state_n == S_START) || (state_n == S_WRITE) || (state_n == S_READ) ||
              (state_n == S_CHECK) || (state_n == S_PASS);
    csb_n   = '1;
    web_n   = 1'b1;
    wmask_n = '0;
    din_n   = '0;
    maddr_n = addr_n[ADDR_W-1:0];
    if (state_n == S_WRITE || state_n == S_READ) begin
      for (int unsigned b = 0; b < NBLOCKS; b++)
        if (k_n == 3'(b)) csb_n[b] = 1'b0;
    end
    if (state_n == S_WRITE) begin
      web_n   = 1'b0;
      wmask_n = '1;
      din_n   = pat_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      addr_q   <= '0;
      status   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fail     <= 1'b0;
      err_blk  <= '0;
      err_addr <= '0;
      csb_q    <= '1;
      web_q    <= 1'b1;
      wmask_q  <= '0;
      maddr_q  <= '0;
      din_q    <= '0;
    end else begin
      state_q  <= state_n;
      k_q      <= k_n;
      addr_q   <= addr_n;
      status   <= status_n;
      busy     <= busy_n;
      done     <= done_n;
      fail     <= fail_n;
      err_blk  <= err_blk_n;
      err_addr <= err_addr_n;
      csb_q    <= csb_n;
      web_q    <= web_n;
      wmask_q  <= wmask_n;
      maddr_q  <= maddr_n;
      din_q    <= din_n;
    end
  end

  assign mem.mem_csb   = csb_q;
  assign mem.mem_web   = web_q;
  assign mem.mem_wmask = wmask_q;
  assign mem.mem_addr  = maddr_q;
  assign mem.mem_din   = din_q;

endmodule
